vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the team's VGA sync/porch generator.
- Takes a porch-shaped HSync/VSync/RGB stream and recovers column and row counts.
- Verifies line and frame lengths against the configured timing, declares lock, and marks the active region.
- Sits after the video source, in the same clock domain, and feeds capture, overlay, and pattern-check logic.

---
 rtl/vga_sync_decoder.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive side of the VGA sync/porch generator. Recovers column/row counts
// from an active-low HSync/VSync stream, measures every line and frame
// against the configured timing, declares lock after LOCK_FRAMES good frames
// and marks the active region. All outputs are registered: the values after
// clock edge N describe the syncs and video sampled at edge N.
//
// Optional feature, macro VGA_SYNC_DECODER_BLANK_EN:
//   defined   - video outputs are forced to 0 whenever o_Active is 0
//   undefined - video outputs are the input video delayed one clock
module vga_sync_decoder #(
  parameter int VIDEO_WIDTH      = 3,
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 10,
  parameter int FRONT_PORCH_VERT = 4,
  parameter int LOCK_FRAMES      = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic                   o_Active,
  output logic                   o_Frame_Start,
  output logic                   o_Locked,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  // Sync falls happen at fixed positions, so the counters are reloaded there.
  localparam logic [9:0]  COL_LAST    = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST    = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]  COL_LOAD    = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [9:0]  ROW_LOAD    = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [9:0]  COL_ACTIVE  = 10'(ACTIVE_COLS);
  localparam logic [9:0]  ROW_ACTIVE  = 10'(ACTIVE_ROWS);
  localparam logic [11:0] LINE_GOOD   = 12'(TOTAL_COLS);
  localparam logic [11:0] WDOG_LAST   = 12'(2 * TOTAL_COLS - 1);
  localparam logic [11:0] LINES_GOOD  = 12'(TOTAL_ROWS);
  localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_FRAMES);

  logic                   r_HSync_Prev, r_VSync_Prev;
  logic [11:0]            r_Line_Len;
  logic [11:0]            r_Lines;
  logic                   r_Bad;
  logic                   r_Seen;
  logic [3:0]             r_Good_Frames;

  logic                   w_HFall, w_VFall, w_Col_Wrap;
  logic [9:0]             w_Col_Next, w_Row_Next;
  logic                   w_Line_Bad, w_Wdog_Trip, w_Frame_Good;
  logic [11:0]            w_Line_Len_Next, w_Lines_Incl, w_Lines_Next;
  logic                   w_Bad_Next, w_Seen_Next, w_Locked_Next;
  logic [3:0]             w_Good_Next;
  logic                   w_Active_Next, w_Frame_Start_Next;
  logic [VIDEO_WIDTH-1:0] w_Red_Next, w_Grn_Next, w_Blu_Next;

  // Sync edge detection and the free-running column/row counters.
  always_comb begin
    w_HFall    = !i_HSync && r_HSync_Prev;
    w_VFall    = !i_VSync && r_VSync_Prev;
    w_Col_Wrap = 1'b0;
    w_Col_Next = o_Col_Count + 10'd1;
    w_Row_Next = o_Row_Count;
    if (w_HFall) begin
      w_Col_Next = COL_LOAD;
    end else if (o_Col_Count == COL_LAST) begin
      w_Col_Next = '0;
      w_Col_Wrap = 1'b1;
    end
    if (w_VFall) begin
      w_Row_Next = ROW_LOAD;
    end else if (w_Col_Wrap) begin
      w_Row_Next = (o_Row_Count == ROW_LAST) ? '0 : o_Row_Count + 10'd1;
    end
  end

  // Line/frame measurement, watchdog and lock qualification. The line check
  // of a coincident HFall is folded in before the frame is judged.
  always_comb begin
    w_Line_Bad      = w_HFall && r_Seen && ((r_Line_Len + 12'd1) != LINE_GOOD);
    w_Line_Len_Next = r_Line_Len;
    if (w_HFall) begin
      w_Line_Len_Next = '0;
    end else if (r_Line_Len != 12'hFFF) begin
      w_Line_Len_Next = r_Line_Len + 12'd1;
    end
    w_Wdog_Trip  = !w_HFall && (r_Line_Len == WDOG_LAST);
    w_Lines_Incl = r_Lines;
    if (w_HFall && (r_Lines != 12'hFFF)) begin
      w_Lines_Incl = r_Lines + 12'd1;
    end
    w_Bad_Next    = r_Bad | w_Line_Bad;
    w_Seen_Next   = r_Seen;
    w_Good_Next   = r_Good_Frames;
    w_Lines_Next  = w_Lines_Incl;
    w_Locked_Next = o_Locked && !w_Line_Bad;
    w_Frame_Good  = r_Seen && !w_Bad_Next && (w_Lines_Incl == LINES_GOOD);
    if (w_VFall) begin
      if (w_Frame_Good) begin
        if (r_Good_Frames != LOCK_TARGET) begin
          w_Good_Next = r_Good_Frames + 4'd1;
        end
        if (w_Good_Next == LOCK_TARGET) begin
          w_Locked_Next = 1'b1;
        end
      end else begin
        w_Good_Next   = '0;
        w_Locked_Next = 1'b0;
      end
      w_Seen_Next  = 1'b1;
      w_Bad_Next   = 1'b0;
      w_Lines_Next = '0;
    end
    // A missing HSync drops everything and forces a fresh reference frame.
    if (w_Wdog_Trip) begin
      w_Locked_Next = 1'b0;
      w_Good_Next   = '0;
      w_Seen_Next   = 1'b0;
      w_Bad_Next    = 1'b1;
    end
  end

  // Region flags and video, computed from the next-state counts and lock.
  always_comb begin
    w_Active_Next      = w_Locked_Next && (w_Col_Next < COL_ACTIVE) &&
                         (w_Row_Next < ROW_ACTIVE);
    w_Frame_Start_Next = w_Locked_Next && (w_Col_Next == '0) && (w_Row_Next == '0);
`ifdef VGA_SYNC_DECODER_BLANK_EN
    w_Red_Next = w_Active_Next ? i_Red_Video : '0;
    w_Grn_Next = w_Active_Next ? i_Grn_Video : '0;
    w_Blu_Next = w_Active_Next ? i_Blu_Video : '0;
`else
    w_Red_Next = i_Red_Video;
    w_Grn_Next = i_Grn_Video;
    w_Blu_Next = i_Blu_Video;
`endif
  end

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_HSync_Prev  <= 1'b1;
      r_VSync_Prev  <= 1'b1;
      r_Line_Len    <= '0;
      r_Lines       <= '0;
      r_Bad         <= 1'b0;
      r_Seen        <= 1'b0;
      r_Good_Frames <= '0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Locked      <= 1'b0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
    end else begin
      r_HSync_Prev  <= i_HSync;
      r_VSync_Prev  <= i_VSync;
      r_Line_Len    <= w_Line_Len_Next;
      r_Lines       <= w_Lines_Next;
      r_Bad         <= w_Bad_Next;
      r_Seen        <= w_Seen_Next;
      r_Good_Frames <= w_Good_Next;
      o_Col_Count   <= w_Col_Next;
      o_Row_Count   <= w_Row_Next;
      o_Active      <= w_Active_Next;
      o_Frame_Start <= w_Frame_Start_Next;
      o_Locked      <= w_Locked_Next;
      o_Red_Video   <= w_Red_Next;
      o_Grn_Video   <= w_Grn_Next;
      o_Blu_Video   <= w_Blu_Next;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down 20x12 raster (active 12x8,
// front porches 2/1, HSync cols 14..16, VSync rows 9..10, lock after 2 frames).
module tb_vga_sync_decoder;

  localparam int TC = 20, TR = 12, AC = 12, AR = 8, FPH = 2, FPV = 1, LF = 2;
  localparam int HS_START = AC + FPH;     // 14
  localparam int HS_END   = HS_START + 3; // 17
  localparam int VS_START = AR + FPV;     // 9
  localparam int VS_END   = VS_START + 2; // 11

  // ---------------- clock / reset / DUT ----------------
  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b1;
  logic       i_HSync = 1'b1, i_VSync = 1'b1;
  logic [2:0] i_Red_Video = '0, i_Grn_Video = '0, i_Blu_Video = '0;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic       o_Active, o_Frame_Start, o_Locked;
  logic [2:0] o_Red_Video, o_Grn_Video, o_Blu_Video;

  always #5 i_Clk = ~i_Clk;

  vga_sync_decoder #(
    .VIDEO_WIDTH(3), .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR), .FRONT_PORCH_HORZ(FPH), .FRONT_PORCH_VERT(FPV),
    .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red_Video(i_Red_Video), .i_Grn_Video(i_Grn_Video), .i_Blu_Video(i_Blu_Video),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count), .o_Active(o_Active),
    .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked),
    .o_Red_Video(o_Red_Video), .o_Grn_Video(o_Grn_Video), .o_Blu_Video(o_Blu_Video)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- generator / expectation state ----------------
  int   gc = 0, gr = 0;         // generator position of the next sample
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  bit   exp_lock = 1'b0;
  bit   in_sync = 1'b0;         // decoder counts expected to equal gc/gr
  bit   pending_bad_hf = 1'b0;  // next HFall ends a wrong-length line
  bit   pending_bad_vf = 1'b0;  // next VFall ends a wrong-length frame
  bit   hold_hs = 1'b0, short_req = 1'b0, skip_req = 1'b0;
  int   vf_cnt = 0;             // VFalls since the last loss of lock
  int   since_hf = 0;           // clocks since the last HFall

  // Asynchronous reset with an immediate all-zero check, one edge in reset.
  task automatic apply_reset();
    i_Rst_L = 1'b0;
    #1;
    chk("rst_col", 32'(o_Col_Count), 32'd0);
    chk("rst_row", 32'(o_Row_Count), 32'd0);
    chk("rst_active", 32'(o_Active), 32'd0);
    chk("rst_fstart", 32'(o_Frame_Start), 32'd0);
    chk("rst_locked", 32'(o_Locked), 32'd0);
    chk("rst_video", 32'({o_Red_Video, o_Grn_Video, o_Blu_Video}), 32'd0);
    @(posedge i_Clk);
    #1;
    i_Rst_L  = 1'b1;
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    exp_lock = 1'b0;
    vf_cnt   = 0;
    in_sync  = 1'b0;
    since_hf = 0;
    pending_bad_hf = 1'b0;
    pending_bad_vf = 1'b0;
  endtask

  // One generator clock: drive the sample at (gc,gr), check after the edge, advance.
  task automatic tick();
    logic hs, vs, is_hf, is_vf, ea, ef;
    logic [2:0] r, g;
    hs = hold_hs ? 1'b1 : !(gc >= HS_START && gc < HS_END);
    vs = !(gr >= VS_START && gr < VS_END);
    r  = 3'(gc);
    g  = 3'(gr);
    i_HSync = hs; i_VSync = vs;
    i_Red_Video = r; i_Grn_Video = g; i_Blu_Video = 3'b101;
    is_hf = !hs && prev_hs;
    is_vf = !vs && prev_vs;
    prev_hs = hs;
    prev_vs = vs;
    if (is_hf) begin
      since_hf = 0;
      if (pending_bad_hf) begin
        pending_bad_hf = 1'b0;
        exp_lock = 1'b0;
        vf_cnt   = 0;
        in_sync  = 1'b1;
      end
    end else begin
      since_hf++;
      if (since_hf == 2 * TC) begin
        exp_lock = 1'b0;
        vf_cnt   = 0;
      end
    end
    if (is_vf) begin
      in_sync = 1'b1;
      if (pending_bad_vf) begin
        pending_bad_vf = 1'b0;
        exp_lock = 1'b0;
        vf_cnt   = 1;
      end else begin
        vf_cnt++;
        if (vf_cnt >= LF + 1) exp_lock = 1'b1;
      end
    end
    ea = exp_lock && (gc < AC) && (gr < AR);
    ef = exp_lock && (gc == 0) && (gr == 0);
    @(posedge i_Clk);
    #1;
    chk("locked", 32'(o_Locked), 32'(exp_lock));
    if (in_sync) begin
      chk("col", 32'(o_Col_Count), 32'(gc));
      chk("row", 32'(o_Row_Count), 32'(gr));
      chk("active", 32'(o_Active), 32'(ea));
      chk("frame_start", 32'(o_Frame_Start), 32'(ef));
`ifdef VGA_SYNC_DECODER_BLANK_EN
      chk("video", 32'({o_Red_Video, o_Grn_Video, o_Blu_Video}),
          32'(ea ? {r, g, 3'b101} : 9'd0));
`endif
    end
`ifndef VGA_SYNC_DECODER_BLANK_EN
    chk("video", 32'({o_Red_Video, o_Grn_Video, o_Blu_Video}), 32'({r, g, 3'b101}));
`endif
    if (short_req && gr == 2 && gc == TC - 2) begin
      short_req = 1'b0; pending_bad_hf = 1'b1; in_sync = 1'b0;
      gc = 0; gr = gr + 1;
    end else if (skip_req && gr == 4 && gc == TC - 1) begin
      skip_req = 1'b0; pending_bad_vf = 1'b1; in_sync = 1'b0;
      gc = 0; gr = 6;
    end else if (gc == TC - 1) begin
      gc = 0;
      gr = (gr == TR - 1) ? 0 : gr + 1;
    end else begin
      gc++;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * TC * TR) tick();
  endtask

  task automatic run_until(input int c, input int r);
    for (int k = 0; k < 2 * TC * TR && !(gc == c && gr == r); k++) tick();
    chk("reach_pos", 32'(gc == c && gr == r), 32'd1);
  endtask

  // ---------------- directed vector table (straight after reset) ----------------
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] vid;
    logic [9:0] col;
    logic [9:0] row;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [2:0] ev;
    vecs[0]  = '{1'b1, 1'b1, 3'd0, 10'd1,  10'd0}; // free-run from 0
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 10'd14, 10'd0}; // HFall loads 12+2
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 10'd15, 10'd0}; // held low: no new fall
    vecs[3]  = '{1'b1, 1'b1, 3'd3, 10'd16, 10'd0};
    vecs[4]  = '{1'b1, 1'b1, 3'd4, 10'd17, 10'd0};
    vecs[5]  = '{1'b1, 1'b1, 3'd5, 10'd18, 10'd0};
    vecs[6]  = '{1'b1, 1'b1, 3'd6, 10'd19, 10'd0};
    vecs[7]  = '{1'b1, 1'b1, 3'd7, 10'd0,  10'd1}; // column wrap bumps row
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 10'd1,  10'd9}; // VFall loads 8+1
    vecs[9]  = '{1'b0, 1'b0, 3'd1, 10'd14, 10'd9}; // VSync still low
    vecs[10] = '{1'b1, 1'b1, 3'd2, 10'd15, 10'd9};
    vecs[11] = '{1'b0, 1'b0, 3'd3, 10'd14, 10'd9}; // coincident falls
    vecs[12] = '{1'b1, 1'b1, 3'd4, 10'd15, 10'd9};
    vecs[13] = '{1'b0, 1'b1, 3'd5, 10'd14, 10'd9};

    #3;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      i_HSync = vecs[i].hs;
      i_VSync = vecs[i].vs;
      i_Red_Video = vecs[i].vid;
      i_Grn_Video = vecs[i].vid ^ 3'b111;
      i_Blu_Video = vecs[i].vid + 3'd2;
      @(posedge i_Clk);
      #1;
      chk("tbl_col", 32'(o_Col_Count), 32'(vecs[i].col));
      chk("tbl_row", 32'(o_Row_Count), 32'(vecs[i].row));
      chk("tbl_flags", 32'({o_Locked, o_Active, o_Frame_Start}), 32'd0);
`ifdef VGA_SYNC_DECODER_BLANK_EN
      ev = 3'd0;
      chk("tbl_video", 32'({o_Red_Video, o_Grn_Video, o_Blu_Video}), 32'({ev, ev, ev}));
`else
      ev = vecs[i].vid;
      chk("tbl_video", 32'({o_Red_Video, o_Grn_Video, o_Blu_Video}),
          32'({ev, ev ^ 3'b111, ev + 3'd2}));
`endif
    end

    // Nominal stream from reset: lock after the third VFall.
    apply_reset();
    gc = 0;
    gr = 0;
    run_frames(4);

    // One 19-clock line: unlock on its HFall, relock two good frames later.
    short_req = 1'b1;
    run_frames(4);

    // HSync stuck high: watchdog unlocks 2*TC clocks after the last HFall.
    run_until(HS_START + 1, 2);
    hold_hs = 1'b1;
    repeat (65) tick();
    hold_hs = 1'b0;
    run_frames(4);

    // Frame with TR-1 lines: unlock at its VFall.
    skip_req = 1'b1;
    run_frames(5);

    // Reset mid-frame, then the nominal relock sequence.
    run_until(10, 5);
    apply_reset();
    run_frames(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
